div: RTL
========

// Module: div
// PURPOSE
//  Multi-cycle 32-bit radix-2 restoring divider serving the EX stage for DIV/DIVU.
//  EX is the initiator: it raises start_i and stalls the pipeline until ready_o.
//  This block is the responder: it returns {remainder, quotient}, which EX forwards
//  on hi_o/lo_o with whilo_o set (HI = remainder, LO = quotient).
// PARAMETERS
//  (none)  Width is fixed at 32 bits through RegBus; iteration count is fixed at 32.
// PORTS
//  clk           in   1   clock; all state changes on the rising edge
//  rst           in   1   reset, asynchronous, active-high (RstEnable = 1'b1)
//  signed_div_i  in   1   1 = DIV (two's-complement), 0 = DIVU
//  opdata1_i     in   32  dividend; sampled only when a start is accepted
//  opdata2_i     in   32  divisor; sampled only when a start is accepted
//  start_i       in   1   request; held high by EX until it has consumed ready_o
//  annul_i       in   1   cancel the in-flight divide (branch-delay flush)
//  result_o      out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o=1
//  ready_o       out  1   result valid
// BEHAVIOUR
//  - Reset: state FREE, result_o = 0, ready_o = 0, count = 0. Reset is async and
//    overrides everything, including an operation mid-ON (clears immediately).
//  - States: FREE, BYZERO, ON, END. count is a 6-bit iteration counter.
//  - FREE: at edge E0 with start_i=1 and annul_i=0, latch operands.
//      divisor==0 -> BYZERO; else -> ON with count=0. start_i together with
//      annul_i is not accepted (stay FREE).
//  - Signed mode: operands are replaced by their magnitudes at latch time. Quotient
//    is negated if the operand signs differ; remainder takes the dividend's sign.
//    0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
//  - ON: one restoring step per edge (E1..E32):
//      diff = {rem[31:0], next dividend bit} - {1'b0, divisor}  (33-bit)
//      diff >= 0 -> rem = diff, qbit = 1; else rem = shifted value, qbit = 0.
//    At E33 (count==32): apply sign fix, register result_o, set ready_o=1, go to END.
//    Total latency: ready_o first high in the cycle after E33.
//  - BYZERO: at E1 go to END with result_o = 0 and ready_o = 1.
//  - END: hold result_o and ready_o while start_i=1. At the first edge with
//    start_i=0: go to FREE, ready_o=0, result_o=0. annul_i is ignored in END.
//  - annul_i=1 in ON or BYZERO: next edge goes to FREE. ready_o stays 0 and
//    result_o stays 0. The partial result is discarded.
//  - A new start is accepted only from FREE. There is at least one FREE cycle
//    between consecutive divides.
//  - Operand inputs changing after acceptance have no effect.
//  - ready_o and result_o are registered. There is no combinational path from the
//    inputs to the outputs.
// STRUCTURE
//  - defines.sv gains: DivFree/DivByZero/DivOn/DivEnd (2-bit state codes),
//    DivResultReady/NotReady, DivStart/Stop, DivAnnul, and DoubleRegBus [63:0].
//    The same constants go into the shared package as a div_state_t enum.
//  - One sub-module, div_step: combinational single restoring step.
//    (rem, divisor, in-bit) -> (rem_next, qbit).
//  - The FSM, counter, operand registers and sign fix-up live in div.
// TESTING
//  1. DIVU 100/7, start held -> ready_o rises after E33; result_o = {32'd2, 32'd14}.
//  2. DIV -7/2 (0xFFFFFFF9/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//  3. DIV 0x80000000/0xFFFFFFFF -> result_o = {32'h0, 32'h80000000}.
//     DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
//  4. Divide 5/0 -> ready_o after E1, result_o = 0.
//     Drop start_i -> FREE, ready_o = 0 on the next edge.
//  5. annul_i at iteration 10 -> FREE next edge, ready_o never rises.
//     An immediate new start 9/3 -> {0, 3} with full latency.
//  6. Async reset pulse mid-ON (between edges) -> ready_o = 0 and result_o = 0
//     immediately. After release, FREE accepts a new start normally.
//  Also: random signed/unsigned operands vs a reference model (/ and %, MIPS
//  semantics), with random start_i release delays in END.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// State codes, handshake levels, bus widths and operand sign helpers.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [5:0] DIV_LAST_ITER = 6'd32;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_ANNUL            = 1'b1;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Magnitude of a two's-complement value; unsigned operands pass through.
  function automatic logic [REG_BUS-1:0] div_magnitude(input logic [REG_BUS-1:0] v,
                                                       input logic is_signed);
    return (is_signed && v[REG_BUS-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [REG_BUS-1:0] div_negate_if(input logic [REG_BUS-1:0] v,
                                                       input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit and try to subtract
// the divisor; keep the difference only when it does not borrow.
module div_step
  import div_pkg::*;
(
  input  logic [REG_BUS-1:0] i_rem,
  input  logic [REG_BUS-1:0] i_divisor,
  input  logic               i_bit,
  output logic [REG_BUS-1:0] o_rem_next,
  output logic               o_qbit
);

  logic [REG_BUS:0]   w_shifted;
  logic [REG_BUS+1:0] w_diff;

  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};

  // A successful subtraction always leaves a value below the divisor, so bit 32
  // can only be set together with the borrow bit.
  assign o_qbit     = ~w_diff[REG_BUS+1] & ~w_diff[REG_BUS];
  assign o_rem_next = o_qbit ? w_diff[REG_BUS-1:0] : w_shifted[REG_BUS-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU: 32 iterations plus one
// fix-up edge, result held until the requester drops start_i.
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_t                r_state;
  logic [5:0]                r_count;
  logic [REG_BUS-1:0]        r_rem;
  logic [REG_BUS-1:0]        r_quot;
  logic [REG_BUS-1:0]        r_divisor;
  logic                      r_neg_q;
  logic                      r_neg_r;
  logic [DOUBLE_REG_BUS-1:0] r_result;
  logic                      r_ready;

  div_state_t                w_state_next;
  logic [5:0]                w_count_next;
  logic [REG_BUS-1:0]        w_rem_next;
  logic [REG_BUS-1:0]        w_quot_next;
  logic [REG_BUS-1:0]        w_divisor_next;
  logic                      w_neg_q_next;
  logic                      w_neg_r_next;
  logic [DOUBLE_REG_BUS-1:0] w_result_next;
  logic                      w_ready_next;

  logic [REG_BUS-1:0]        w_step_rem;
  logic                      w_step_qbit;

  // r_quot starts as the dividend magnitude; its MSB feeds each step and the
  // quotient bits shift in from the bottom.
  div_step u_step (
    .i_rem      (r_rem),
    .i_divisor  (r_divisor),
    .i_bit      (r_quot[REG_BUS-1]),
    .o_rem_next (w_step_rem),
    .o_qbit     (w_step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_rem     <= w_rem_next;
      r_quot    <= w_quot_next;
      r_divisor <= w_divisor_next;
      r_neg_q   <= w_neg_q_next;
      r_neg_r   <= w_neg_r_next;
      r_result  <= w_result_next;
      r_ready   <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_rem_next     = r_rem;
    w_quot_next    = r_quot;
    w_divisor_next = r_divisor;
    w_neg_q_next   = r_neg_q;
    w_neg_r_next   = r_neg_r;
    w_result_next  = r_result;
    w_ready_next   = r_ready;

    case (r_state)
      DIV_FREE: begin
        if (start_i == DIV_START && annul_i != DIV_ANNUL) begin
          w_quot_next    = div_magnitude(opdata1_i, signed_div_i);
          w_divisor_next = div_magnitude(opdata2_i, signed_div_i);
          w_rem_next     = '0;
          w_count_next   = '0;
          w_neg_q_next   = signed_div_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
          w_neg_r_next   = signed_div_i & opdata1_i[REG_BUS-1];
          w_state_next   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end

      DIV_BY_ZERO: begin
        if (annul_i == DIV_ANNUL) begin
          w_state_next = DIV_FREE;
        end else begin
          w_result_next = '0;
          w_ready_next  = DIV_RESULT_READY;
          w_state_next  = DIV_END;
        end
      end

      DIV_ON: begin
        if (annul_i == DIV_ANNUL) begin
          w_state_next = DIV_FREE;
        end else if (r_count == DIV_LAST_ITER) begin
          w_result_next = {div_negate_if(r_rem, r_neg_r), div_negate_if(r_quot, r_neg_q)};
          w_ready_next  = DIV_RESULT_READY;
          w_state_next  = DIV_END;
        end else begin
          w_rem_next   = w_step_rem;
          w_quot_next  = {r_quot[REG_BUS-2:0], w_step_qbit};
          w_count_next = r_count + 6'd1;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_result_next = '0;
          w_ready_next  = DIV_RESULT_NOT_READY;
          w_state_next  = DIV_FREE;
        end
      end

      default: begin
        w_state_next = DIV_FREE;
      end
    endcase
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
